// File: rtl/bcd_pkg.sv
// Shared BCD definitions used by the digit stage and the multi-digit counter.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_ZERO = 4'd0;

  typedef logic [3:0] bcd_digit_t;

  // Non-decimal codes (A..F) are forced to 9 so a display never shows garbage.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_multi_down_counter_if.sv
// Control/status bundle for the multi-digit BCD down counter.
// master = controller driving the counter, slave = the counter itself.
interface bcd_multi_down_counter_if #(
  parameter int DIGITS = 2
) ();

  logic                  ena;
  logic                  ena_cnt;
  logic                  loadN;
  logic [4*DIGITS-1:0]   datain;
  logic [4*DIGITS-1:0]   count;
  logic                  zero;
  logic                  tc;
  logic                  expired;

  modport master (
    output ena, ena_cnt, loadN, datain,
    input  count, zero, tc, expired
  );

  modport slave (
    input  ena, ena_cnt, loadN, datain,
    output count, zero, tc, expired
  );

endinterface

// File: rtl/bcd_digit_stage.sv
// One decade of the BCD down counter: load with clamping, or decrement with
// 0 -> 9 borrow when the top level enables it.
module bcd_digit_stage
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_en,
  input  logic       load,
  input  bcd_digit_t load_val,
  output bcd_digit_t digit,
  output logic       is_zero
);

  bcd_digit_t digit_reg;

  // Digit register: reset > load > decrement > hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      digit_reg <= BCD_ZERO;
    end else if (load) begin
      digit_reg <= bcd_clamp(load_val);
    end else if (dec_en) begin
      digit_reg <= (digit_reg == BCD_ZERO) ? BCD_MAX : digit_reg - 4'd1;
    end
  end

  assign digit   = digit_reg;
  assign is_zero = (digit_reg == BCD_ZERO);

endmodule

// File: rtl/bcd_multi_down_counter.sv
// DIGITS-wide BCD down counter built from cascaded decade stages with a purely
// combinational borrow chain, wrap/hold at zero, a terminal-count pulse and a
// sticky expired flag.
module bcd_multi_down_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
) (
  input logic                     clk,
  input logic                     reset,
  bcd_multi_down_counter_if.slave bus
);

  localparam int CW = 4 * DIGITS;

  logic              load;
  logic              tick;
  logic              tick_eff;
  logic              at_one;
  logic [CW-1:0]     count_w;
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS:0]   lower_zero;
  logic [DIGITS-1:0] dec_en;
  logic              tc_reg;

  assign load = ~bus.loadN;
  assign tick = bus.ena & bus.ena_cnt;

  // lower_zero[i] is high when every digit below i reads 0; lower_zero[DIGITS]
  // is therefore the whole-count zero flag.
  assign lower_zero[0] = 1'b1;

  // In hold mode a tick at zero is swallowed; in wrap mode it falls through
  // the borrow chain and turns every digit into 9.
  assign tick_eff = tick & (WRAP | ~lower_zero[DIGITS]);

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_stage
      assign lower_zero[gi+1] = lower_zero[gi] & digit_zero[gi];
      assign dec_en[gi]       = tick_eff & lower_zero[gi];

      bcd_digit_stage u_stage (
        .clk      (clk),
        .reset    (reset),
        .dec_en   (dec_en[gi]),
        .load     (load),
        .load_val (bus.datain[4*gi +: 4]),
        .digit    (count_w[4*gi +: 4]),
        .is_zero  (digit_zero[gi])
      );
    end
  endgenerate

  // A tick while the count is exactly 1 is the decrement that reaches zero.
  assign at_one = (count_w == CW'(1));

  // Terminal-count pulse, valid for the single cycle after reaching zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      tc_reg <= 1'b0;
    end else if (load) begin
      tc_reg <= 1'b0;
    end else begin
      tc_reg <= tick & at_one;
    end
  end

  generate
    if (WRAP) begin : g_wrap
      assign bus.expired = 1'b0;
    end else begin : g_hold
      logic expired_reg;

      // Sticky expired flag: set on reaching zero, cleared only by load/reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          expired_reg <= 1'b0;
        end else if (load) begin
          expired_reg <= 1'b0;
        end else if (tick & at_one) begin
          expired_reg <= 1'b1;
        end
      end

      assign bus.expired = expired_reg;
    end
  endgenerate

  assign bus.count = count_w;
  assign bus.zero  = lower_zero[DIGITS];
  assign bus.tc    = tc_reg;

endmodule
